// File: rtl/fetch_debug_controller.sv
// Debug/loader controller for the instruction-fetch stage.
// A host talks to it over a byte link: 'L' loads words into instruction RAM,
// 'C' runs the pipeline until HALT retires, and 'S' enters single-step mode,
// where 'N' steps one cycle and 'E' leaves. After a halt or a step the PC is
// sent back MSB first. A completed load is acknowledged with 'K'.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   in_rx_data/in_rx_done received byte and its one-cycle valid pulse
//   in_tx_done            transmitter finished the current byte
//   in_halt_detected      pipeline has retired HALT (level)
//   in_pc                 current PC from the fetch stage
//   out_pipeline_enable   fetch/pipeline advance enable
//   out_mem_we/addr/data  instruction RAM write port
//   out_tx_start/data     one-cycle start pulse and byte to transmit
module fetch_debug_controller #(
   parameter int unsigned    len        = 32,
   parameter int unsigned    ADDR_WIDTH = 11,
   parameter int unsigned    RAM_DEPTH  = 2048,
   parameter logic [len-1:0] HALT_WORD  = {len{1'b1}}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_rx_data,
   input  logic                  in_rx_done,
   input  logic                  in_tx_done,
   input  logic                  in_halt_detected,
   input  logic [len-1:0]        in_pc,
   output logic                  out_pipeline_enable,
   output logic                  out_mem_we,
   output logic [ADDR_WIDTH-1:0] out_mem_addr,
   output logic [len-1:0]        out_mem_data,
   output logic                  out_tx_start,
   output logic [7:0]            out_tx_data
);

   localparam int unsigned           BYTES     = len / 8;
   localparam int unsigned           CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_CONT = 8'h43;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] CMD_NEXT = 8'h4E;
   localparam logic [7:0] CMD_END  = 8'h45;
   localparam logic [7:0] ACK_BYTE = 8'h4B;

   typedef enum logic [2:0] {
      IDLE, LOAD, WRITE, RUN, STEP_WAIT, STEP_PULSE, SEND_PC, SEND_ACK
   } state_t;

   state_t                state;
   logic [CNT_W-1:0]      byte_cnt;
   logic [CNT_W-1:0]      tx_idx;
   logic [ADDR_WIDTH-1:0] addr;
   logic [len-1:0]        word;
   logic [len-1:0]        word_next;
   logic [len-1:0]        pc_snap;
   logic [len-1:0]        pc_shifted;
   logic                  from_step;
   logic                  pc_go_c;

   // Bytes arrive MSB first, so each new byte shifts in at the bottom.
   assign word_next  = (word << 8) | len'(in_rx_data);
   // The snapshot is consumed from the top, one byte per transmitted byte.
   assign pc_shifted = pc_snap << 8;

   // Conditions that start a PC report: halt while running, a step that just
   // completed, or an 'N' arriving when the pipeline is already halted.
   always_comb begin
      pc_go_c = 1'b0;
      case (state)
         RUN:        pc_go_c = in_halt_detected;
         STEP_WAIT:  pc_go_c = in_rx_done && (in_rx_data == CMD_NEXT) && in_halt_detected;
         STEP_PULSE: pc_go_c = 1'b1;
         default:    pc_go_c = 1'b0;
      endcase
   end

   // Controller state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state               <= IDLE;
         byte_cnt            <= '0;
         tx_idx              <= '0;
         addr                <= '0;
         word                <= '0;
         pc_snap             <= '0;
         from_step           <= 1'b0;
         out_pipeline_enable <= 1'b0;
         out_mem_we          <= 1'b0;
         out_mem_addr        <= '0;
         out_mem_data        <= '0;
         out_tx_start        <= 1'b0;
         out_tx_data         <= '0;
      end else begin
         out_mem_we   <= 1'b0;
         out_tx_start <= 1'b0;

         case (state)
            IDLE: begin
               if (in_rx_done) begin
                  case (in_rx_data)
                     CMD_LOAD: begin
                        state    <= LOAD;
                        addr     <= '0;
                        byte_cnt <= '0;
                     end
                     CMD_CONT: begin
                        state               <= RUN;
                        out_pipeline_enable <= 1'b1;
                     end
                     CMD_STEP: state <= STEP_WAIT;
                     default: ;
                  endcase
               end
            end

            LOAD: begin
               if (in_rx_done) begin
                  word <= word_next;
                  if (byte_cnt == LAST_BYTE) begin
                     out_mem_we   <= 1'b1;
                     out_mem_addr <= addr;
                     out_mem_data <= word_next;
                     byte_cnt     <= '0;
                     state        <= WRITE;
                  end else begin
                     byte_cnt <= byte_cnt + CNT_W'(1);
                  end
               end
            end

            // Ends on the HALT word (which is itself written) or at the last
            // RAM word, so the address never wraps onto word 0.
            WRITE: begin
               byte_cnt <= '0;
               if ((out_mem_data == HALT_WORD) || (addr == LAST_ADDR)) begin
                  state        <= SEND_ACK;
                  out_tx_start <= 1'b1;
                  out_tx_data  <= ACK_BYTE;
               end else begin
                  addr  <= addr + ADDR_WIDTH'(1);
                  state <= LOAD;
               end
            end

            RUN: begin
               if (in_halt_detected) out_pipeline_enable <= 1'b0;
            end

            STEP_WAIT: begin
               if (in_rx_done) begin
                  case (in_rx_data)
                     CMD_NEXT: begin
                        if (!in_halt_detected) begin
                           state               <= STEP_PULSE;
                           out_pipeline_enable <= 1'b1;
                        end
                     end
                     CMD_END: state <= IDLE;
                     default: ;
                  endcase
               end
            end

            STEP_PULSE: out_pipeline_enable <= 1'b0;

            SEND_PC: begin
               if (in_tx_done) begin
                  if (tx_idx == LAST_BYTE) begin
                     state <= (from_step && !in_halt_detected) ? STEP_WAIT : IDLE;
                  end else begin
                     tx_idx       <= tx_idx + CNT_W'(1);
                     pc_snap      <= pc_shifted;
                     out_tx_data  <= pc_shifted[len-1 -: 8];
                     out_tx_start <= 1'b1;
                  end
               end
            end

            SEND_ACK: begin
               if (in_tx_done) state <= IDLE;
            end

            default: state <= IDLE;
         endcase

         // Entering the PC report: capture the PC and launch its top byte.
         if (pc_go_c) begin
            state        <= SEND_PC;
            pc_snap      <= in_pc;
            tx_idx       <= '0;
            out_tx_data  <= in_pc[len-1 -: 8];
            out_tx_start <= 1'b1;
            from_step    <= (state == STEP_PULSE);
         end
      end
   end

endmodule

// File: tb/tb_fetch_debug_controller.sv
// Bench for fetch_debug_controller: directed host commands, a fetch-stage PC
// stand-in, a transmitter responder, and a per-cycle compare process that
// checks writes, transmitted bytes and the enable window against expectations.
module tb_fetch_debug_controller;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic [7:0]  rx_data   = 8'h00;
   logic        rx_done   = 1'b0;
   logic        tx_done   = 1'b0;
   logic        halt      = 1'b0;
   logic [31:0] in_pc     = 32'h0;
   logic        pipeline_enable;
   logic        mem_we;
   logic [10:0] mem_addr;
   logic [31:0] mem_data;
   logic        tx_start;
   logic [7:0]  tx_data;

   int          n_checks  = 0;
   int          n_fail    = 0;
   int          cyc       = 0;
   bit          checking  = 1'b0;
   bit          pc_clear  = 1'b1;
   int          en_lo     = 1;
   int          en_hi     = 0;
   int          en_count  = 0;
   int          start_due = -1;
   int          last_rx_cyc = 0;
   bit          tx_busy   = 1'b0;
   logic [7:0]  tx_hold   = 8'h00;

   logic [10:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic [7:0]  tq[$];
   int          start_cycles[$];

   fetch_debug_controller dut (
      .clk                 (clk),
      .reset               (reset),
      .in_rx_data          (rx_data),
      .in_rx_done          (rx_done),
      .in_tx_done          (tx_done),
      .in_halt_detected    (halt),
      .in_pc               (in_pc),
      .out_pipeline_enable (pipeline_enable),
      .out_mem_we          (mem_we),
      .out_mem_addr        (mem_addr),
      .out_mem_data        (mem_data),
      .out_tx_start        (tx_start),
      .out_tx_data         (tx_data)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Fetch-stage stand-in: PC advances by one during every enabled cycle.
   initial forever begin
      @(negedge clk);
      if (pc_clear) in_pc = 32'h0;
      else if (pipeline_enable) in_pc = in_pc + 32'd1;
   end

   // Transmitter: finishes each byte a few cycles after its start pulse.
   initial begin
      int d;
      d = 0;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            repeat (2 + d % 3) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
            d++;
         end
      end
   end

   // Per-cycle comparison against the expectation queues and enable window.
   initial forever begin
      @(negedge clk);
      if (checking) begin
         if (start_due == cyc) chk("tx_start_after_done", 64'(tx_start), 64'd1);
         chk("pipeline_enable", 64'(pipeline_enable), 64'((cyc >= en_lo) && (cyc <= en_hi)));
         en_count += int'(pipeline_enable);
         if (mem_we) begin
            chk("write_expected", 64'(wa_q.size() != 0), 64'd1);
            if (wa_q.size() != 0) begin
               chk("mem_addr", 64'(mem_addr), 64'(wa_q.pop_front()));
               chk("mem_data", 64'(mem_data), 64'(wd_q.pop_front()));
            end
         end
         if (tx_start) begin
            chk("tx_start_while_busy", 64'(tx_busy), 64'd0);
            chk("tx_expected", 64'(tq.size() != 0), 64'd1);
            if (tq.size() != 0) chk("tx_data", 64'(tx_data), 64'(tq.pop_front()));
            tx_busy = 1'b1;
            tx_hold = tx_data;
            start_cycles.push_back(cyc);
         end else if (tx_busy) begin
            chk("tx_data_stable", 64'(tx_data), 64'(tx_hold));
         end
         if (tx_done && tx_busy) begin
            tx_busy = 1'b0;
            if (tq.size() != 0) start_due = cyc + 1;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data     = b;
      rx_done     = 1'b1;
      last_rx_cyc = cyc;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
   endtask

   task automatic push_tx_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) tq.push_back(w[8*i +: 8]);
   endtask

   task automatic push_write(input int a, input logic [31:0] w);
      wa_q.push_back(11'(a));
      wd_q.push_back(w);
   endtask

   // Bounded wait for all expected writes and bytes to be consumed.
   task automatic wait_quiet(input string name);
      int n;
      n = 0;
      while ((tq.size() != 0 || tx_busy || wa_q.size() != 0) && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk(name, 64'(tq.size() + wa_q.size() + int'(tx_busy)), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_enable"},   64'(pipeline_enable), 64'd0);
      chk({name, "_mem_we"},   64'(mem_we),          64'd0);
      chk({name, "_mem_addr"}, 64'(mem_addr),        64'd0);
      chk({name, "_mem_data"}, 64'(mem_data),        64'd0);
      chk({name, "_tx_start"}, 64'(tx_start),        64'd0);
      chk({name, "_tx_data"},  64'(tx_data),         64'd0);
   endtask

   task automatic clear_pc();
      pc_clear = 1'b1;
      @(posedge clk);
      #1;
      pc_clear = 1'b0;
      en_count = 0;
   endtask

   initial begin
      int t;
      int e0;
      repeat (3) @(posedge clk);
      checking = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      reset    = 1'b1;
      pc_clear = 1'b0;

      // Load terminated by the HALT word, acknowledged with 'K'.
      push_write(0, 32'h2008_0005);
      push_write(1, 32'hFFFF_FFFF);
      tq.push_back(8'h4B);
      send_byte(8'h4C);
      send_word(32'h2008_0005);
      send_word(32'hFFFF_FFFF);
      wait_quiet("load_halt");
      chk("mem_addr_hold", 64'(mem_addr), 64'd1);
      chk("mem_data_hold", 64'(mem_data), 64'hFFFF_FFFF);

      // Continuous run, halt 10 cycles after 'C', PC 0x0A reported.
      clear_pc();
      push_tx_word(32'h0000_000A);
      send_byte(8'h43);
      t     = last_rx_cyc;
      en_lo = t + 1;
      en_hi = t + 10;
      while (cyc < t + 10) begin
         @(posedge clk);
         #1;
      end
      halt = 1'b1;
      wait_quiet("run_pc");
      chk("run_enable_cycles", 64'(en_count), 64'd10);
      halt = 1'b0;

      // Single steps: one enable cycle each, PC 1, 2, 3 reported.
      clear_pc();
      send_byte(8'h53);
      for (int k = 1; k <= 3; k++) begin
         push_tx_word(32'(k));
         start_cycles.delete();
         e0 = en_count;
         send_byte(8'h4E);
         t     = last_rx_cyc;
         en_lo = t + 1;
         en_hi = t + 1;
         wait_quiet("step_pc");
         chk("step_enable_cycles", 64'(en_count - e0), 64'd1);
         chk("step_first_start", 64'(start_cycles.size() > 0 ? start_cycles[0] : 0), 64'(t + 2));
      end
      send_byte(8'h45);
      e0 = en_count;
      send_byte(8'h4E);
      repeat (6) @(posedge clk);
      #1;
      chk("idle_ignores_n", 64'(en_count - e0), 64'd0);

      // 'N' with the pipeline already halted: report only, no pulse.
      send_byte(8'h53);
      halt = 1'b1;
      push_tx_word(32'h0000_0003);
      e0 = en_count;
      send_byte(8'h4E);
      wait_quiet("halted_step_pc");
      halt = 1'b0;
      send_byte(8'h4E);
      repeat (6) @(posedge clk);
      #1;
      chk("halted_step_no_enable", 64'(en_count - e0), 64'd0);

      // Garbage in IDLE, then a 'C' dropped while the PC is being sent.
      send_byte(8'h41);
      repeat (4) @(posedge clk);
      #1;
      clear_pc();
      push_tx_word(32'h0000_0003);
      send_byte(8'h43);
      t     = last_rx_cyc;
      en_lo = t + 1;
      en_hi = t + 3;
      while (cyc < t + 3) begin
         @(posedge clk);
         #1;
      end
      halt = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send_byte(8'h43);
      wait_quiet("garbage_pc");
      repeat (6) @(posedge clk);
      #1;
      chk("garbage_enable_cycles", 64'(en_count), 64'd3);
      halt = 1'b0;

      // Reset in the middle of a word: the next load starts clean at 0.
      send_byte(8'h4C);
      send_byte(8'hDE);
      send_byte(8'hAD);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midreset");
      @(posedge clk);
      #1;
      reset = 1'b1;
      push_write(0, 32'h1122_3344);
      push_write(1, 32'hFFFF_FFFF);
      tq.push_back(8'h4B);
      send_byte(8'h4C);
      send_word(32'h1122_3344);
      send_word(32'hFFFF_FFFF);
      wait_quiet("reload");

      // Full-depth load without HALT: stops at the last word, no wrap.
      for (int i = 0; i < 2048; i++) push_write(i, 32'hA500_0000 | 32'(i));
      tq.push_back(8'h4B);
      send_byte(8'h4C);
      for (int i = 0; i < 2048; i++) send_word(32'hA500_0000 | 32'(i));
      wait_quiet("full_load");
      repeat (20) @(posedge clk);
      #1;
      chk("full_load_last_addr", 64'(mem_addr), 64'd2047);
      chk("full_load_last_data", 64'(mem_data), 64'hA500_07FF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_debug_controller.md
Name: fetch_debug_controller

Overview:
- Debug/loader controller that sequences the instruction-fetch stage and its instruction RAM from a host over a byte link (UART rx/tx handshakes).
- Loads a program into instruction memory, then runs the pipeline continuously or one cycle at a time by driving the fetch stage's enable (stall_flag).
- Reports the PC back to the host after a halt and after every step.

Parameters:
- len, 32, datapath/instruction width in bits (multiple of 8).
- ADDR_WIDTH, 11, instruction memory address width.
- RAM_DEPTH, 2048, instruction memory depth in words.
- HALT_WORD, 32'hFFFFFFFF, instruction word that ends a load.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous reset, active-low.
- in_rx_data  in  8  received byte.
- in_rx_done  in  1  one-cycle pulse: in_rx_data valid.
- in_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- in_halt_detected  in  1  pipeline has retired the HALT instruction (level).
- in_pc  in  len  current PC from the fetch stage.
- out_pipeline_enable  out  1  fetch/pipeline enable (stall_flag); 1 = advance.
- out_mem_we  out  1  instruction RAM write strobe.
- out_mem_addr  out  ADDR_WIDTH  RAM write address.
- out_mem_data  out  len  RAM write data.
- out_tx_start  out  1  one-cycle pulse: start sending out_tx_data.
- out_tx_data  out  8  byte to send.

Behaviour:
- Reset (reset==0 at posedge): state IDLE; every output 0; byte counter, write address and PC snapshot cleared. Reset mid-operation aborts the load, run or transmit immediately, with no partial write.
- States: IDLE, LOAD, WRITE, RUN, STEP_WAIT, STEP_PULSE, SEND_PC, SEND_ACK.
- IDLE, on in_rx_done:
  - 'L' (0x4C) -> LOAD, address reset to 0.
  - 'C' (0x43) -> RUN.
  - 'S' (0x53) -> STEP_WAIT.
  - Any other byte is ignored.
- LOAD:
  - Assembles len/8 bytes, MSB first; the 4th in_rx_done moves to WRITE.
- WRITE (one cycle):
  - out_mem_we=1 with the assembled word and the current address.
  - Next cycle: address+1 and bytes cleared.
  - If word==HALT_WORD or address==RAM_DEPTH-1 -> SEND_ACK; else -> LOAD.
  - The HALT word itself is written; the address never wraps.
- RUN:
  - out_pipeline_enable=1 from the cycle after the 'C' pulse.
  - When in_halt_detected=1, enable drops to 0 in that same registered cycle boundary; then -> SEND_PC.
  - in_rx_done is ignored while in RUN.
- STEP_WAIT:
  - Enable stays 0.
  - 'N' (0x4E) -> STEP_PULSE.
  - 'E' (0x45) -> IDLE.
  - Any other byte is ignored.
  - If in_halt_detected is already 1, an 'N' gives no pulse and goes directly to SEND_PC.
- STEP_PULSE: enable=1 for exactly one cycle, then -> SEND_PC.
- SEND_PC:
  - On entry, snapshot in_pc (the post-step/post-halt value).
  - Send len/8 bytes MSB first. Each byte: out_tx_start pulses 1 cycle with out_tx_data stable until in_tx_done; the next byte's start comes the cycle after in_tx_done.
  - After the last in_tx_done: go to STEP_WAIT if entered from a step without a halt, else IDLE.
- SEND_ACK: send one byte 'K' (0x4B) with the same handshake, then -> IDLE.
- in_rx_done during SEND_PC or SEND_ACK is dropped.
- Output timing:
  - out_mem_* and out_tx_* are registered.
  - out_mem_addr/out_mem_data hold their last value when out_mem_we=0.
  - out_pipeline_enable is 0 in every state except RUN and STEP_PULSE.
- Latency:
  - 'N' rx_done at cycle t -> enable=1 at t+1 only -> first out_tx_start at t+2.
  - 4th load byte at t -> out_mem_we at t+1.

Test Plan:
- 'L', then bytes 20 08 00 05, then FF FF FF FF -> two we pulses: addr0=0x20080005, addr1=0xFFFFFFFF; then tx 'K'; state IDLE.
- 'C' with in_halt_detected rising 10 cycles later and in_pc=0x0000000A -> enable high for exactly 10 cycles, then tx bytes 00 00 00 0A, each start waiting on tx_done.
- 'S', then 'N' three times with in_pc incrementing by 1 per enable -> each 'N' gives exactly 1 enable cycle and tx of the PC (1, 2, 3); then 'E' -> IDLE, enable 0.
- Load of 2048 words with no HALT word -> last write at addr 2047, then 'K'; no write at addr 0 afterwards.
- reset low after 2 of 4 load bytes, then 'L' plus 4 fresh bytes -> the single write goes to addr 0 with only the fresh word; no stale bytes.
- Garbage byte 0x41 in IDLE and 'C' during SEND_PC -> no state change, no enable, transmission intact.
